fft_arm_ctrl: RTL and testbench
===============================

# fft_arm_ctrl

Parametrised FFT arming controller that sits between the front-panel keys and the FFT/RAM capture path. After any key activity it holds the FFT off until all keys have been released for a programmable settle time, then asserts `fft_valid` until the capture path reports completion on `fft_shutdown`. It adds three features: N keys, an optional automatic re-arm with a programmable gap, and a completed-frame counter.

## Interface

Parameters:
- `KEY_NUM`, default 2: number of active-low key inputs (≥1).
- `DELAY`, default 50_000: settle time in clk cycles with all keys released (≥1; 1 ms at 50 MHz).
- `CNT_W`, default 16: settle/gap counter width; must hold `max(DELAY, REARM_GAP)`.
- `AUTO_REARM`, default 0: 0 = one capture per key event; 1 = re-arm automatically after each shutdown.
- `REARM_GAP`, default 16: cycles `fft_valid` stays low between automatic captures (≥1; used only when `AUTO_REARM=1`).
- `FRAME_W`, default 8: width of `frame_cnt`.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key`, input, `KEY_NUM`: keys, active-low. Any bit low counts as "key active". Inputs are already synchronised.
- `fft_shutdown`, input, 1: level/pulse from the capture path meaning "RAM write done".
- `fft_valid`, output, 1: FFT enable level.
- `fft_start`, output, 1: one-cycle pulse on the first cycle of each `fft_valid` high period.
- `busy`, output, 1: high in SETTLE or GAP.
- `frame_cnt`, output, `FRAME_W`: number of completed captures since the last key event. Wraps modulo 2^FRAME_W.

## Operation

State machine with four states: IDLE, SETTLE, RUN, GAP. All outputs are registered.

Key handling:
- Key active in any state: next state is SETTLE, `cnt` is 0, `frame_cnt` is 0, `fft_valid` is 0.
- Key has priority over every other event, including `fft_shutdown` on the same edge.

Transitions:
- **IDLE:** waits. `fft_shutdown` is ignored.
- **SETTLE:** on each edge sampling all keys high, `cnt` increments. On the edge where `cnt == DELAY-1`:
  - next state is RUN;
  - `cnt` is 0;
  - `fft_valid` goes to 1 and `fft_start` goes to 1.
  - A key active while in SETTLE restarts the count from 0 (re-trigger, not accumulate).
- **RUN:** `fft_valid` stays 1. When `fft_shutdown` is sampled high:
  - `fft_valid` goes to 0;
  - `frame_cnt` increments;
  - next state is GAP if `AUTO_REARM=1`, otherwise IDLE.
- **GAP:** `cnt` increments each cycle. On the edge where `cnt == REARM_GAP-1`:
  - next state is RUN;
  - `fft_valid` goes to 1 and `fft_start` goes to 1;
  - `cnt` is 0.
  - `fft_shutdown` is ignored in GAP.

Other rules:
- `fft_start` is high only on the cycle after a transition into RUN, and low otherwise.
- `busy` is 1 exactly when state is SETTLE or GAP.
- `fft_shutdown` held high for multiple cycles produces exactly one increment, because RUN is left on the first edge.

## Timing

Reset values: state IDLE, `cnt` 0, `fft_valid` 0, `fft_start` 0, `busy` 0, `frame_cnt` 0. Reset asserted mid-operation returns to these values immediately (asynchronously), and no output pulse is produced on release.

Latencies:
- **Key release to `fft_valid`:** `fft_valid` rises at the DELAY-th consecutive rising edge that samples all keys high, counting the first such edge as edge 1.
- **Shutdown to `fft_valid`:** `fft_shutdown` sampled at edge e gives `fft_valid` low from edge e.
- **Auto re-arm:** `fft_valid` is low for exactly `REARM_GAP` cycles, then high again at edge e+REARM_GAP. `fft_start` is high in the same cycle.
- **Key to `fft_valid` low:** a key sampled active at edge k gives `fft_valid` low, `frame_cnt` 0 and `busy` 1 from edge k.

Boundary conditions:
- With `DELAY=1`, the first all-high edge goes straight to RUN.
- `frame_cnt` wraps from 2^FRAME_W−1 to 0 with no flag.

## Test plan

- **Basic arm/shutdown:** `DELAY=8`, `AUTO_REARM=0`; pulse `key[0]` low for 3 cycles, then release → `busy`=1 for 8 cycles, `fft_valid` and `fft_start` rise at the 8th released edge, `fft_start` lasts 1 cycle. Then `fft_shutdown` for 1 cycle → `fft_valid`=0 next edge, `frame_cnt`=1, state IDLE. A further `fft_shutdown` has no effect.
- **Re-trigger:** `DELAY=8`; release the key, then assert `key[1]` low at released-edge 5, release again → `fft_valid` rises only after 8 fresh released edges, 13+ cycles after the first release.
- **Auto re-arm:** `AUTO_REARM=1`, `REARM_GAP=4`; three `fft_shutdown` pulses during RUN → each gap has `fft_valid` low for exactly 4 cycles, there are 4 `fft_start` pulses in total, and `frame_cnt`=3.
- **Priority:** in RUN, assert a key and `fft_shutdown` on the same edge → state SETTLE, `frame_cnt`=0, no increment.
- **Held shutdown and wrap:** `FRAME_W=2`, `AUTO_REARM=1`; hold `fft_shutdown` high for 10 cycles per capture, run 5 captures → one increment per capture, `frame_cnt` sequence 1,2,3,0,1.
- **Reset mid-SETTLE/RUN:** assert `rst_n` low asynchronously between edges → all outputs 0 immediately. After release, the block stays IDLE with `fft_valid`=0 until a key event occurs.

Source files
------------

// File: rtl/fft_arm_ctrl.sv
// FFT arming controller.
// Holds the FFT capture path off while any front-panel key is active and
// until all keys have stayed released for DELAY cycles. It then raises
// fft_valid until the capture path signals completion on fft_shutdown.
// With AUTO_REARM set, a new capture starts after a REARM_GAP-cycle gap.
// frame_cnt counts the captures completed since the last key event.
module fft_arm_ctrl #(
  parameter int KEY_NUM    = 2,
  parameter int DELAY      = 50_000,
  parameter int CNT_W      = 16,
  parameter int AUTO_REARM = 0,
  parameter int REARM_GAP  = 16,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  input  logic               fft_shutdown,
  output logic               fft_valid,
  output logic               fft_start,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Terminal counts: the counter starts at 0 on entry to SETTLE or GAP.
  // The exit edge is the one that samples the last value.
  localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(REARM_GAP - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
  localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               valid_r;
  logic               valid_nxt_s;
  logic               start_r;
  logic               start_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic [FRAME_W-1:0] frame_r;
  logic [FRAME_W-1:0] frame_nxt_s;
  logic               key_active_s;

  // Keys are active-low, so any zero bit means a key is held.
  assign key_active_s = ~(&key);

  // Compute the next state and the next output values. Key activity wins over everything else.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    valid_nxt_s = valid_r;
    start_nxt_s = 1'b0;
    frame_nxt_s = frame_r;
    if (key_active_s) begin
      state_nxt_s = ST_SETTLE;
      cnt_nxt_s   = CNT_ZERO;
      valid_nxt_s = 1'b0;
      frame_nxt_s = FRAME_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_nxt_s = 1'b0;
        end
        ST_SETTLE: begin
          if (cnt_r == DELAY_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
            valid_nxt_s = 1'b1;
            start_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            valid_nxt_s = 1'b0;
          end
        end
        ST_RUN: begin
          if (fft_shutdown) begin
            state_nxt_s = (AUTO_REARM != 0) ? ST_GAP : ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            valid_nxt_s = 1'b0;
            frame_nxt_s = frame_r + FRAME_ONE;
          end else begin
            valid_nxt_s = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
            valid_nxt_s = 1'b1;
            start_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            valid_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          valid_nxt_s = 1'b0;
        end
      endcase
    end
    busy_nxt_s = (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_GAP);
  end

  // Register the state and all outputs. Reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      valid_r <= 1'b0;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      frame_r <= FRAME_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= valid_nxt_s;
      start_r <= start_nxt_s;
      busy_r  <= busy_nxt_s;
      frame_r <= frame_nxt_s;
    end
  end

  assign fft_valid = valid_r;
  assign fft_start = start_r;
  assign busy      = busy_r;
  assign frame_cnt = frame_r;

endmodule

// File: tb/tb_fft_arm_ctrl.sv
// Testbench for fft_arm_ctrl.
// Three instances share the stimulus: A is manual re-arm with DELAY=8.
// B auto re-arms with REARM_GAP=4. C auto re-arms with DELAY=1,
// REARM_GAP=12 and a 2-bit frame counter.
// A reference model of released-edge counts is stepped on every edge.
module tb_fft_arm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic       sd;

  logic       valid_a, start_a, busy_a;
  logic [7:0] frame_a;
  logic       valid_b, start_b, busy_b;
  logic [7:0] frame_b;
  logic       valid_c, start_c, busy_c;
  logic [1:0] frame_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_arm_ctrl #(.KEY_NUM(2), .DELAY(8), .CNT_W(8), .AUTO_REARM(0),
                 .REARM_GAP(16), .FRAME_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .key(key), .fft_shutdown(sd),
    .fft_valid(valid_a), .fft_start(start_a), .busy(busy_a), .frame_cnt(frame_a));

  fft_arm_ctrl #(.KEY_NUM(2), .DELAY(8), .CNT_W(8), .AUTO_REARM(1),
                 .REARM_GAP(4), .FRAME_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .key(key), .fft_shutdown(sd),
    .fft_valid(valid_b), .fft_start(start_b), .busy(busy_b), .frame_cnt(frame_b));

  fft_arm_ctrl #(.KEY_NUM(2), .DELAY(1), .CNT_W(4), .AUTO_REARM(1),
                 .REARM_GAP(12), .FRAME_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .key(key), .fft_shutdown(sd),
    .fft_valid(valid_c), .fft_start(start_c), .busy(busy_c), .frame_cnt(frame_c));

  // Observed outputs packed as {valid, start, busy, frame[7:0]}.
  logic [10:0] obs [3];
  assign obs[0] = {valid_a, start_a, busy_a, frame_a};
  assign obs[1] = {valid_b, start_b, busy_b, frame_b};
  assign obs[2] = {valid_c, start_c, busy_c, 6'd0, frame_c};

  // Reference model: parameters and behavioural state per instance.
  int p_delay [3] = '{8, 8, 1};
  int p_auto  [3] = '{0, 1, 1};
  int p_gap   [3] = '{16, 4, 12};
  int p_fw    [3] = '{8, 8, 2};
  bit m_valid [3];
  bit m_start [3];
  bit m_settle[3];
  bit m_ingap [3];
  int m_rel   [3];
  int m_gapcnt[3];
  int m_frame [3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 0; m_start[d] = 0; m_settle[d] = 0; m_ingap[d] = 0;
      m_rel[d] = 0; m_gapcnt[d] = 0; m_frame[d] = 0;
    end
  endtask

  // The model works from released-edge counts since the last key event and elapsed gap length.
  task automatic model_step(input bit key_act, input bit shut);
    for (int d = 0; d < 3; d++) begin
      m_start[d] = 0;
      if (key_act) begin
        m_settle[d] = 1; m_rel[d] = 0; m_ingap[d] = 0;
        m_valid[d] = 0; m_frame[d] = 0;
      end else if (m_settle[d]) begin
        m_rel[d]++;
        if (m_rel[d] == p_delay[d]) begin
          m_settle[d] = 0; m_valid[d] = 1; m_start[d] = 1;
        end
      end else if (m_valid[d]) begin
        if (shut) begin
          m_valid[d] = 0;
          m_frame[d] = (m_frame[d] + 1) % (1 << p_fw[d]);
          if (p_auto[d] != 0) begin
            m_ingap[d] = 1; m_gapcnt[d] = 0;
          end
        end
      end else if (m_ingap[d]) begin
        m_gapcnt[d]++;
        if (m_gapcnt[d] == p_gap[d]) begin
          m_ingap[d] = 0; m_valid[d] = 1; m_start[d] = 1;
        end
      end
    end
  endtask

  function automatic logic [10:0] exp_word(input int d);
    logic [7:0] f;
    f = 8'(m_frame[d]);
    return {m_valid[d], m_start[d], (m_settle[d] | m_ingap[d]), f};
  endfunction

  // One clock: the model samples the same inputs as the DUTs, and outputs are then read at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(key != 2'b11, sd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== 11'd0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d got %h want %h", d, obs[d], 11'd0);
      end
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== exp_word(d)) begin
        n_bad++;
        $display("FAIL reset_idle dut%0d got %h want %h", d, obs[d], exp_word(d));
      end
    end
  endtask

  task automatic test_basic();
    key = 2'b10;
    for (int i = 0; i < 3; i++) tick();
    key = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs[d] !== exp_word(d)) begin
          n_bad++;
          $display("FAIL basic_settle dut%0d edge%0d got %h want %h", d, i, obs[d], exp_word(d));
        end
      end
    end
    n_cmp++;
    if ({valid_a, start_a} !== 2'b11) begin
      n_bad++;
      $display("FAIL basic_arm got %b want 11", {valid_a, start_a});
    end
    tick();
    n_cmp++;
    if ({valid_a, start_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_start_width got %b want 10", {valid_a, start_a});
    end
    sd = 1'b1; tick(); sd = 1'b0;
    n_cmp++;
    if ({valid_a, busy_a, frame_a} !== {2'b00, 8'd1}) begin
      n_bad++;
      $display("FAIL basic_shutdown got %h want %h", {valid_a, busy_a, frame_a}, {2'b00, 8'd1});
    end
    tick(); sd = 1'b1; tick(); sd = 1'b0; tick();
    n_cmp++;
    if ({valid_a, busy_a, frame_a} !== {2'b00, 8'd1}) begin
      n_bad++;
      $display("FAIL basic_idle_shutdown got %h want %h", {valid_a, busy_a, frame_a}, {2'b00, 8'd1});
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== exp_word(d)) begin
        n_bad++;
        $display("FAIL basic_end dut%0d got %h want %h", d, obs[d], exp_word(d));
      end
    end
  endtask

  task automatic test_retrigger();
    int n;
    key = 2'b10; tick(); key = 2'b11;
    for (int i = 1; i <= 4; i++) tick();
    key = 2'b01; tick(); key = 2'b11;
    n = 0;
    while (valid_a !== 1'b1 && n < 30) begin
      tick();
      n++;
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs[d] !== exp_word(d)) begin
          n_bad++;
          $display("FAIL retrig dut%0d got %h want %h", d, obs[d], exp_word(d));
        end
      end
    end
    n_cmp++;
    if (n !== 8) begin
      n_bad++;
      $display("FAIL retrig_latency got %0d want 8", n);
    end
  endtask

  task automatic test_auto_rearm();
    int n, starts, low;
    key = 2'b10; tick(); key = 2'b11;
    n = 0; starts = 0;
    while (valid_b !== 1'b1 && n < 20) begin
      tick(); n++;
      if (start_b === 1'b1) starts++;
    end
    for (int p = 0; p < 3; p++) begin
      int run_len;
      run_len = $urandom_range(2, 6);
      for (int i = 0; i < run_len; i++) begin
        tick();
        if (start_b === 1'b1) starts++;
      end
      sd = 1'b1; tick(); sd = 1'b0;
      low = (valid_b === 1'b0) ? 1 : 0;
      n = 0;
      while (valid_b !== 1'b1 && n < 20) begin
        tick(); n++;
        if (valid_b === 1'b0) low++;
        if (start_b === 1'b1) starts++;
        for (int d = 0; d < 3; d++) begin
          n_cmp++;
          if (obs[d] !== exp_word(d)) begin
            n_bad++;
            $display("FAIL rearm dut%0d got %h want %h", d, obs[d], exp_word(d));
          end
        end
      end
      n_cmp++;
      if (low !== 4) begin
        n_bad++;
        $display("FAIL rearm_gap%0d got %0d want 4", p, low);
      end
    end
    n_cmp++;
    if (starts !== 4 || frame_b !== 8'd3) begin
      n_bad++;
      $display("FAIL rearm_totals starts %0d frame %0d want 4 and 3", starts, frame_b);
    end
  endtask

  task automatic test_priority();
    key = 2'b10; sd = 1'b1; tick(); key = 2'b11; sd = 1'b0;
    n_cmp++;
    if ({valid_b, busy_b, frame_b} !== {2'b01, 8'd0}) begin
      n_bad++;
      $display("FAIL priority got %h want %h", {valid_b, busy_b, frame_b}, {2'b01, 8'd0});
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== exp_word(d)) begin
        n_bad++;
        $display("FAIL priority_model dut%0d got %h want %h", d, obs[d], exp_word(d));
      end
    end
  endtask

  task automatic test_held_wrap();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int n;
    key = 2'b10; tick(); key = 2'b11;
    for (int c = 0; c < 5; c++) begin
      n = 0;
      while (valid_c !== 1'b1 && n < 30) begin
        tick(); n++;
      end
      sd = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        for (int d = 0; d < 3; d++) begin
          n_cmp++;
          if (obs[d] !== exp_word(d)) begin
            n_bad++;
            $display("FAIL held dut%0d got %h want %h", d, obs[d], exp_word(d));
          end
        end
      end
      sd = 1'b0;
      n_cmp++;
      if (frame_c !== seq[c]) begin
        n_bad++;
        $display("FAIL wrap_seq%0d got %0d want %0d", c, frame_c, seq[c]);
      end
    end
  endtask

  task automatic test_reset_mid(input int run_first);
    int n;
    key = 2'b10; tick(); key = 2'b11;
    n = 0;
    if (run_first != 0) begin
      while (valid_a !== 1'b1 && n < 20) begin
        tick(); n++;
      end
    end else begin
      tick(); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== 11'd0) begin
        n_bad++;
        $display("FAIL async_reset%0d dut%0d got %h want 0", run_first, d, obs[d]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs[d] !== exp_word(d)) begin
          n_bad++;
          $display("FAIL post_reset dut%0d got %h want %h", d, obs[d], exp_word(d));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      key = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      sd  = ($urandom_range(0, 3) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (obs[d] !== exp_word(d)) begin
          n_bad++;
          $display("FAIL random dut%0d cyc%0d got %h want %h", d, i, obs[d], exp_word(d));
        end
      end
    end
    key = 2'b11; sd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key = 2'b11; sd = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_retrigger();
    test_auto_rearm();
    test_priority();
    test_held_wrap();
    test_reset_mid(0);
    test_reset_mid(1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
